// File: rtl/multi_cycle_control_unit.sv
// Control FSM for the shared multi-cycle RV32I datapath: walks each instruction through
// IF/ID/EX/MEM/WB, drives all datapath enables and selects, and halts on the exit ecall.
module multi_cycle_control_unit #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic [31:0]      x17_val,
   input  logic             bcond,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             old_pc_write,
   output logic             pc_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             alu_op,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             is_halted,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpSystem = 7'b1110011;

   localparam logic [1:0] SrcAPc    = 2'b00;
   localparam logic [1:0] SrcAReg   = 2'b01;
   localparam logic [1:0] SrcAOldPc = 2'b10;
   localparam logic [1:0] SrcAZero  = 2'b11;
   localparam logic [1:0] SrcBReg   = 2'b00;
   localparam logic [1:0] SrcBFour  = 2'b01;
   localparam logic [1:0] SrcBImm   = 2'b10;
   localparam logic [1:0] WbAlu     = 2'b00;
   localparam logic [1:0] WbMdr     = 2'b01;
   localparam logic [1:0] WbPc      = 2'b10;

   typedef enum logic [2:0] {
      StIf   = 3'd0,
      StId   = 3'd1,
      StEx   = 3'd2,
      StMem  = 3'd3,
      StWb   = 3'd4,
      StHalt = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q;
   logic             retire;
   logic             is_load;

   assign is_load = (opcode == OpLoad);
   assign state   = state_q;
   assign retired = retired_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIf;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d      = state_q;
      retire       = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      i_or_d       = 1'b0;
      ir_write     = 1'b0;
      old_pc_write = 1'b0;
      pc_write     = 1'b0;
      alu_src_a    = SrcAPc;
      alu_src_b    = SrcBReg;
      alu_op       = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = WbAlu;
      is_halted    = 1'b0;

      case (state_q)
         StIf: begin
            mem_read  = 1'b1;
            alu_src_a = SrcAPc;
            alu_src_b = SrcBFour;
            if (mem_ready) begin
               ir_write     = 1'b1;
               old_pc_write = 1'b1;
               pc_write     = 1'b1;
               state_d      = StId;
            end
         end
         StId: begin
            if (opcode == OpSystem) begin
               if (x17_val == 32'd10) begin
                  state_d = StHalt;
               end else begin
                  state_d = StIf;
                  retire  = 1'b1;
               end
            end else begin
               state_d = StEx;
            end
         end
         StEx: begin
            case (opcode)
               OpR: begin
                  alu_src_a = SrcAReg;
                  alu_src_b = SrcBReg;
                  alu_op    = 1'b1;
                  state_d   = StWb;
               end
               OpImm: begin
                  alu_src_a = SrcAReg;
                  alu_src_b = SrcBImm;
                  alu_op    = 1'b1;
                  state_d   = StWb;
               end
               OpLoad, OpStore: begin
                  alu_src_a = SrcAReg;
                  alu_src_b = SrcBImm;
                  state_d   = StMem;
               end
               OpBranch: begin
                  alu_src_a = SrcAOldPc;
                  alu_src_b = SrcBImm;
                  pc_write  = bcond;
                  state_d   = StIf;
                  retire    = 1'b1;
               end
               // PC already holds OLD_PC+4, so the link value comes straight from PC.
               OpJal, OpJalr: begin
                  alu_src_a = (opcode == OpJalr) ? SrcAReg : SrcAOldPc;
                  alu_src_b = SrcBImm;
                  pc_write  = 1'b1;
                  reg_write = 1'b1;
                  wb_sel    = WbPc;
                  state_d   = StIf;
                  retire    = 1'b1;
               end
               OpLui: begin
                  alu_src_a = SrcAZero;
                  alu_src_b = SrcBImm;
                  state_d   = StWb;
               end
               OpAuipc: begin
                  alu_src_a = SrcAOldPc;
                  alu_src_b = SrcBImm;
                  state_d   = StWb;
               end
               default: begin
                  state_d = StIf;
                  retire  = 1'b1;
               end
            endcase
         end
         StMem: begin
            i_or_d    = 1'b1;
            mem_read  = is_load;
            mem_write = !is_load;
            if (mem_ready) begin
               state_d = is_load ? StWb : StIf;
               retire  = !is_load;
            end
         end
         StWb: begin
            reg_write = 1'b1;
            wb_sel    = is_load ? WbMdr : WbAlu;
            state_d   = StIf;
            retire    = 1'b1;
         end
         StHalt: begin
            is_halted = 1'b1;
         end
         default: begin
            state_d = StIf;
         end
      endcase

      // Outputs are forced quiet while reset is held, aborting any memory access at once.
      if (!reset) begin
         mem_read     = 1'b0;
         mem_write    = 1'b0;
         i_or_d       = 1'b0;
         ir_write     = 1'b0;
         old_pc_write = 1'b0;
         pc_write     = 1'b0;
         alu_src_a    = SrcAPc;
         alu_src_b    = SrcBReg;
         alu_op       = 1'b0;
         reg_write    = 1'b0;
         wb_sel       = WbAlu;
         is_halted    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit: walks hand-sequenced instructions and
// compares {state, control vector} and the retired count every cycle.
module tb_multi_cycle_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  opcode;
   logic [31:0] x17_val;
   logic        bcond;
   logic        mem_ready;
   logic        mem_read, mem_write, i_or_d, ir_write, old_pc_write, pc_write;
   logic [1:0]  alu_src_a, alu_src_b, wb_sel;
   logic        alu_op, reg_write, is_halted;
   logic [2:0]  state;
   logic [31:0] retired;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_ret = 0;

   // {state, mr mw iod, ir opc pcw, src_a, src_b, alu_op, reg_write, wb_sel, is_halted}
   logic [17:0] obs;
   assign obs = {state, mem_read, mem_write, i_or_d, ir_write, old_pc_write, pc_write,
                 alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, is_halted};

   localparam logic [17:0] E_RST     = {3'd0, 15'b000_000_00_00_0_0_00_0};
   localparam logic [17:0] E_IF      = {3'd0, 15'b100_111_00_01_0_0_00_0};
   localparam logic [17:0] E_IF_WAIT = {3'd0, 15'b100_000_00_01_0_0_00_0};
   localparam logic [17:0] E_ID      = {3'd1, 15'b000_000_00_00_0_0_00_0};
   localparam logic [17:0] E_EX_R    = {3'd2, 15'b000_000_01_00_1_0_00_0};
   localparam logic [17:0] E_EX_I    = {3'd2, 15'b000_000_01_10_1_0_00_0};
   localparam logic [17:0] E_EX_LS   = {3'd2, 15'b000_000_01_10_0_0_00_0};
   localparam logic [17:0] E_EX_BR0  = {3'd2, 15'b000_000_10_10_0_0_00_0};
   localparam logic [17:0] E_EX_BR1  = {3'd2, 15'b000_001_10_10_0_0_00_0};
   localparam logic [17:0] E_EX_JAL  = {3'd2, 15'b000_001_10_10_0_1_10_0};
   localparam logic [17:0] E_EX_JALR = {3'd2, 15'b000_001_01_10_0_1_10_0};
   localparam logic [17:0] E_EX_LUI  = {3'd2, 15'b000_000_11_10_0_0_00_0};
   localparam logic [17:0] E_EX_NOP  = {3'd2, 15'b000_000_00_00_0_0_00_0};
   localparam logic [17:0] E_MEM_LD  = {3'd3, 15'b101_000_00_00_0_0_00_0};
   localparam logic [17:0] E_MEM_ST  = {3'd3, 15'b011_000_00_00_0_0_00_0};
   localparam logic [17:0] E_WB_ALU  = {3'd4, 15'b000_000_00_00_0_1_00_0};
   localparam logic [17:0] E_WB_LD   = {3'd4, 15'b000_000_00_00_0_1_01_0};
   localparam logic [17:0] E_HALT    = {3'd5, 15'b000_000_00_00_0_0_00_1};

   multi_cycle_control_unit dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .x17_val      (x17_val),
      .bcond        (bcond),
      .mem_ready    (mem_ready),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .i_or_d       (i_or_d),
      .ir_write     (ir_write),
      .old_pc_write (old_pc_write),
      .pc_write     (pc_write),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .reg_write    (reg_write),
      .wb_sel       (wb_sel),
      .is_halted    (is_halted),
      .state        (state),
      .retired      (retired)
   );

   always #5 clk = ~clk;

   // Land 1 time unit after the rising edge; inputs change here, checks follow #1 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; opcode = 7'b0000011; mem_ready = 1'b0; x17_val = 0; bcond = 0;
      repeat (2) tick();
      #1;
      total++; if (obs !== E_RST) begin bad++;
         $display("FAIL reset_ctl got=%h want=%h", obs, E_RST); end
      total++; if (retired !== 32'd0) begin bad++;
         $display("FAIL reset_retired got=%0d want=0", retired); end
      tick();
      reset = 1'b1;
   endtask

   task automatic test_add();
      opcode = 7'b0110011; mem_ready = 1'b1;
      #1; total++; if (obs !== E_IF) begin bad++;
         $display("FAIL add_if got=%h want=%h", obs, E_IF); end
      tick(); #1; total++; if (obs !== E_ID) begin bad++;
         $display("FAIL add_id got=%h want=%h", obs, E_ID); end
      tick(); #1; total++; if (obs !== E_EX_R) begin bad++;
         $display("FAIL add_ex got=%h want=%h", obs, E_EX_R); end
      tick(); #1; total++; if (obs !== E_WB_ALU) begin bad++;
         $display("FAIL add_wb got=%h want=%h", obs, E_WB_ALU); end
      tick(); exp_ret++;
      #1; total++; if ({state, retired} !== {3'd0, exp_ret}) begin bad++;
         $display("FAIL add_retire got=%0d/%0d want=0/%0d", state, retired, exp_ret); end
   endtask

   task automatic test_addi_lui();
      opcode = 7'b0010011;
      tick(); tick(); #1; total++; if (obs !== E_EX_I) begin bad++;
         $display("FAIL addi_ex got=%h want=%h", obs, E_EX_I); end
      tick(); tick(); exp_ret++;
      opcode = 7'b0110111;
      tick(); tick(); #1; total++; if (obs !== E_EX_LUI) begin bad++;
         $display("FAIL lui_ex got=%h want=%h", obs, E_EX_LUI); end
      tick(); #1; total++; if (obs !== E_WB_ALU) begin bad++;
         $display("FAIL lui_wb got=%h want=%h", obs, E_WB_ALU); end
      tick(); exp_ret++;
   endtask

   task automatic test_load_wait();
      opcode = 7'b0000011; mem_ready = 1'b1;
      tick(); tick(); mem_ready = 1'b0;
      #1; total++; if (obs !== E_EX_LS) begin bad++;
         $display("FAIL lw_ex got=%h want=%h", obs, E_EX_LS); end
      for (int i = 0; i < 3; i++) begin
         tick(); #1; total++; if (obs !== E_MEM_LD) begin bad++;
            $display("FAIL lw_mem_wait%0d got=%h want=%h", i, obs, E_MEM_LD); end
      end
      tick(); mem_ready = 1'b1;
      #1; total++; if (obs !== E_MEM_LD) begin bad++;
         $display("FAIL lw_mem_done got=%h want=%h", obs, E_MEM_LD); end
      tick(); #1; total++; if (obs !== E_WB_LD) begin bad++;
         $display("FAIL lw_wb got=%h want=%h", obs, E_WB_LD); end
      tick(); exp_ret++;
      #1; total++; if ({state, retired} !== {3'd0, exp_ret}) begin bad++;
         $display("FAIL lw_retire got=%0d/%0d want=0/%0d", state, retired, exp_ret); end
   endtask

   task automatic test_branch();
      opcode = 7'b1100011; mem_ready = 1'b1; bcond = 1'b0;
      tick(); tick(); #1; total++; if (obs !== E_EX_BR0) begin bad++;
         $display("FAIL beq_nt_ex got=%h want=%h", obs, E_EX_BR0); end
      tick(); exp_ret++;
      #1; total++; if (state !== 3'd0) begin bad++;
         $display("FAIL beq_nt_back got=%0d want=0", state); end
      bcond = 1'b1;
      tick(); tick(); #1; total++; if (obs !== E_EX_BR1) begin bad++;
         $display("FAIL beq_t_ex got=%h want=%h", obs, E_EX_BR1); end
      tick(); exp_ret++; bcond = 1'b0;
      #1; total++; if ({state, retired} !== {3'd0, exp_ret}) begin bad++;
         $display("FAIL beq_retire got=%0d/%0d want=0/%0d", state, retired, exp_ret); end
   endtask

   task automatic test_jumps();
      opcode = 7'b1101111;
      tick(); tick(); #1; total++; if (obs !== E_EX_JAL) begin bad++;
         $display("FAIL jal_ex got=%h want=%h", obs, E_EX_JAL); end
      tick(); exp_ret++;
      opcode = 7'b1100111;
      tick(); tick(); #1; total++; if (obs !== E_EX_JALR) begin bad++;
         $display("FAIL jalr_ex got=%h want=%h", obs, E_EX_JALR); end
      tick(); exp_ret++;
      opcode = 7'b1111111;
      tick(); tick(); #1; total++; if (obs !== E_EX_NOP) begin bad++;
         $display("FAIL unknown_ex got=%h want=%h", obs, E_EX_NOP); end
      tick(); exp_ret++;
      #1; total++; if ({state, retired} !== {3'd0, exp_ret}) begin bad++;
         $display("FAIL jump_retire got=%0d/%0d want=0/%0d", state, retired, exp_ret); end
   endtask

   task automatic test_ecall();
      opcode = 7'b1110011; x17_val = 32'd5;
      tick(); #1; total++; if (obs !== E_ID) begin bad++;
         $display("FAIL ecall5_id got=%h want=%h", obs, E_ID); end
      tick(); exp_ret++;
      #1; total++; if ({obs, retired} !== {E_IF, exp_ret}) begin bad++;
         $display("FAIL ecall5_back got=%h/%0d want=%h/%0d", obs, retired, E_IF, exp_ret); end
      x17_val = 32'd10;
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         #1; total++; if ({obs, retired} !== {E_HALT, exp_ret}) begin bad++;
            $display("FAIL halt%0d got=%h/%0d want=%h/%0d", i, obs, retired, E_HALT, exp_ret); end
         tick();
      end
      x17_val = 32'd0;
      reset = 1'b0; exp_ret = 0;
      #1; total++; if ({obs, retired} !== {E_RST, exp_ret}) begin bad++;
         $display("FAIL halt_reset got=%h/%0d want=%h/0", obs, retired, E_RST); end
      tick(); reset = 1'b1;
   endtask

   task automatic test_store();
      opcode = 7'b0100011; mem_ready = 1'b0;
      #1; total++; if (obs !== E_IF_WAIT) begin bad++;
         $display("FAIL sw_if_wait got=%h want=%h", obs, E_IF_WAIT); end
      tick(); mem_ready = 1'b1;
      #1; total++; if (obs !== E_IF) begin bad++;
         $display("FAIL sw_if got=%h want=%h", obs, E_IF); end
      tick(); tick(); tick();
      #1; total++; if (obs !== E_MEM_ST) begin bad++;
         $display("FAIL sw_mem got=%h want=%h", obs, E_MEM_ST); end
      tick(); exp_ret++;
      #1; total++; if ({state, retired} !== {3'd0, exp_ret}) begin bad++;
         $display("FAIL sw_retire got=%0d/%0d want=0/%0d", state, retired, exp_ret); end
   endtask

   task automatic test_reset_mid_mem();
      opcode = 7'b0100011; mem_ready = 1'b1;
      tick(); tick(); mem_ready = 1'b0;
      tick();
      #1; total++; if (obs !== E_MEM_ST) begin bad++;
         $display("FAIL abort_pre got=%h want=%h", obs, E_MEM_ST); end
      #1 reset = 1'b0;
      #1; total++; if ({obs, retired} !== {E_RST, 32'd0}) begin bad++;
         $display("FAIL abort_async got=%h/%0d want=%h/0", obs, retired, E_RST); end
      tick(); reset = 1'b1; mem_ready = 1'b1;
      #1; total++; if ({obs, retired} !== {E_IF, 32'd0}) begin bad++;
         $display("FAIL abort_release got=%h/%0d want=%h/0", obs, retired, E_IF); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_addi_lui();
      test_load_wait();
      test_branch();
      test_jumps();
      test_ecall();
      test_store();
      test_reset_mid_mem();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- FSM controller that sequences the shared multi-cycle RV32I datapath: one ALU, one unified instruction/data memory port, one register-file write port.
- Each instruction walks through IF/ID/EX/MEM/WB states; only the states it needs are visited.
- Generates every datapath enable and mux select per cycle, stalls on the memory handshake, and halts on ecall with x17 == 10.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  IR[6:0]; stable from the end of IF.
- x17_val  input  32  register x17 read value; valid in ID.
- bcond  input  1  branch-comparator result; valid in EX.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load IR and MDR from memory.
- old_pc_write  output  1  latch PC into OLD_PC.
- pc_write  output  1  PC update enable.
- alu_src_a  output  2  00 = PC, 01 = A, 10 = OLD_PC, 11 = zero.
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = imm.
- alu_op  output  1  0 = ADD, 1 = decode funct3/funct7.
- reg_write  output  1  register-file write enable.
- wb_sel  output  2  00 = ALUOut, 01 = MDR, 10 = PC.
- is_halted  output  1  core halted.
- state  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (reset low), asynchronous: state = IF, retired = 0. All outputs are 0 while reset is held, including mem_read. IF outputs apply from the first cycle after release. Reset during MEM aborts the access and drops mem_read/mem_write immediately.
- Defaults: all enables 0, selects 00, alu_op 0, unless a state rule below says otherwise.
- IF:
  - mem_read = 1, i_or_d = 0, alu_src_a = PC, alu_src_b = 4.
  - mem_read stays high while mem_ready = 0 (wait state; unbounded).
  - On mem_ready, in the same cycle: ir_write, old_pc_write, and pc_write (PC <= PC+4); next state ID.
- ID:
  - A/B latch in the datapath.
  - opcode == ECALL (1110011): if x17_val == 10 -> HALT; else -> IF (retire).
  - Any other opcode -> EX.
- EX, by opcode:
  - R-type (0110011): alu_src_a = A, alu_src_b = B, alu_op = 1; -> WB.
  - I-arith (0010011): alu_src_a = A, alu_src_b = imm, alu_op = 1; -> WB.
  - LOAD (0000011) / STORE (0100011): alu_src_a = A, alu_src_b = imm, ADD; -> MEM.
  - BRANCH (1100011): alu_src_a = OLD_PC, alu_src_b = imm, ADD; pc_write = bcond; -> IF (retire).
  - JAL (1101111): alu_src_a = OLD_PC, alu_src_b = imm; pc_write = 1; reg_write = 1 with wb_sel = PC (already OLD_PC+4; the register file samples the old PC this edge); -> IF (retire).
  - JALR (1100111): same as JAL except alu_src_a = A. The datapath clears target bit 0.
  - LUI (0110111): alu_src_a = zero, alu_src_b = imm; -> WB.
  - AUIPC (0010111): alu_src_a = OLD_PC, alu_src_b = imm; -> WB.
  - Unknown opcode: treated as a NOP, no enables; -> IF (retire).
- MEM:
  - i_or_d = 1; mem_read = 1 for LOAD, mem_write = 1 for STORE; held until mem_ready.
  - On mem_ready, in the same cycle: LOAD asserts ir_write-free MDR capture and goes -> WB; STORE goes -> IF (retire).
- WB: reg_write = 1; wb_sel = MDR for LOAD, ALUOut otherwise; -> IF (retire).
- HALT: is_halted = 1, all enables 0; stays in HALT until reset. mem_ready is ignored.
- mem_ready is ignored outside IF and MEM.
- retire: retired increments by 1 on the edge that leaves the final state of an instruction. It wraps modulo 2^CNT_W. The halting ecall does not retire.
- Latency with mem_ready tied to 1: ALU ops 4 cycles, load 5, store 4, branch/jump 3, non-halting ecall 2.

Test Plan:
- mem_ready = 1, run add x3,x1,x2 -> state sequence 0,1,2,4,0; reg_write asserted in WB only; retired = 1.
- lw, with mem_ready delayed 3 cycles in MEM -> mem_read and i_or_d = 1 held 4 cycles; wb_sel = 01 in WB; 8 cycles total.
- beq, bcond = 0 then bcond = 1 -> pc_write is 0 in EX, then 1 in EX with alu_src_a = 10; 3 cycles each.
- jal -> in one EX cycle: pc_write = 1, reg_write = 1, wb_sel = 10.
- ecall with x17 = 5 -> returns to IF after 2 cycles; ecall with x17 = 10 -> state = 5, is_halted = 1, retired unchanged.
- Assert reset mid-MEM store -> mem_write falls asynchronously; after release, state = 0 and retired = 0.
